// File: rtl/leaf_hub_endpoint.sv
// Leaf endpoint on a hub link: filters hub words by ID into an RX FIFO and
// tags local payloads into a 2-entry TX skid buffer. Optional drop_count port
// is built when LEAF_HUB_ENDPOINT_DROP_COUNT_EN is defined.
module leaf_hub_endpoint #(
  parameter int HUB_FIFO_WIDTH    = 16,
  parameter int MASTER_FIFO_WIDTH = 8,
  parameter int FPGAID            = 1,
  parameter int RX_DEPTH          = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HUB_FIFO_WIDTH-1:0]    hub_in_data,
  input  logic                         hub_in_valid,
  output logic                         hub_in_ready,
  output logic [HUB_FIFO_WIDTH-1:0]    hub_out_data,
  output logic                         hub_out_valid,
  input  logic                         hub_out_ready,
  output logic [MASTER_FIFO_WIDTH-1:0] local_out_data,
  output logic                         local_out_valid,
  input  logic                         local_out_ready,
  input  logic [MASTER_FIFO_WIDTH-1:0] local_in_data,
  input  logic                         local_in_valid,
  output logic                         local_in_ready,
  input  logic                         local_has_message_flying,
  input  logic                         local_has_odd_clusters,
  output logic                         hub_has_message_flying,
  output logic                         hub_has_odd_clusters,
  output logic [1:0]                   tx_state_dbg
`ifdef LEAF_HUB_ENDPOINT_DROP_COUNT_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  // Handshake: a word moves when valid and ready are both high at a rising
  // clk edge; valid never waits on ready.
  localparam int HDR_W = HUB_FIFO_WIDTH - MASTER_FIFO_WIDTH;
  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [HDR_W-1:0] MY_ID = HDR_W'(FPGAID);
  localparam logic [HDR_W-1:0] BCAST = '1;

  typedef enum logic [1:0] {
    TX_EMPTY = 2'd0,
    TX_ONE   = 2'd1,
    TX_TWO   = 2'd2
  } tx_state_t;

  logic [MASTER_FIFO_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] rx_count;
  logic [HDR_W-1:0] hdr;
  logic id_match, rx_full, rx_empty, rx_push, rx_pop, hub_accept, drop;

  tx_state_t tx_state;
  logic [MASTER_FIFO_WIDTH-1:0] tx_head, tx_tail;
  logic tx_push, tx_pop;

  assign hdr      = hub_in_data[HUB_FIFO_WIDTH-1:MASTER_FIFO_WIDTH];
  assign id_match = (hdr == MY_ID) || (hdr == BCAST);
  assign rx_full  = (rx_count == CNT_W'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign local_out_valid = !rx_empty;
  assign local_out_data  = rx_mem[rd_ptr];
  assign rx_pop          = local_out_valid && local_out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign hub_in_ready    = !reset && (!rx_full || rx_pop);
  assign hub_accept      = hub_in_valid && hub_in_ready;
  assign rx_push         = hub_accept && id_match;
  assign drop            = hub_accept && !id_match;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr] <= hub_in_data[MASTER_FIFO_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  assign local_in_ready = !reset && (tx_state != TX_TWO);
  assign hub_out_valid  = (tx_state != TX_EMPTY);
  assign hub_out_data   = {MY_ID, tx_head};
  assign tx_push        = local_in_valid && local_in_ready;
  assign tx_pop         = hub_out_valid && hub_out_ready;
  assign tx_state_dbg   = tx_state;

  // tx_head is always the oldest word; tx_tail only holds data in TX_TWO.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_EMPTY;
    end else begin
      case (tx_state)
        TX_EMPTY: if (tx_push) begin
          tx_head  <= local_in_data;
          tx_state <= TX_ONE;
        end
        TX_ONE: case ({tx_push, tx_pop})
          2'b10: begin
            tx_tail  <= local_in_data;
            tx_state <= TX_TWO;
          end
          2'b01:   tx_state <= TX_EMPTY;
          2'b11:   tx_head  <= local_in_data;
          default: tx_state <= TX_ONE;
        endcase
        TX_TWO: if (tx_pop) begin
          tx_head  <= tx_tail;
          tx_state <= TX_ONE;
        end
        default: tx_state <= TX_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hub_has_message_flying <= 1'b0;
      hub_has_odd_clusters   <= 1'b0;
    end else begin
      hub_has_message_flying <= local_has_message_flying || !rx_empty ||
                                (tx_state != TX_EMPTY) || hub_in_valid;
      hub_has_odd_clusters   <= local_has_odd_clusters;
    end
  end

`ifdef LEAF_HUB_ENDPOINT_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_leaf_hub_endpoint.sv
// Bench for leaf_hub_endpoint: directed vector table, hand-written reset
// sequence, then randomized traffic checked against a queue-based model.
module tb_leaf_hub_endpoint;
  localparam int HW = 16;
  localparam int MW = 8;
  localparam int DEPTH = 4;
  localparam logic [7:0] MY_ID = 8'h01;

  logic clk = 1'b0;
  logic reset;
  logic [HW-1:0] hub_in_data;
  logic hub_in_valid, hub_in_ready;
  logic [HW-1:0] hub_out_data;
  logic hub_out_valid, hub_out_ready;
  logic [MW-1:0] local_out_data;
  logic local_out_valid, local_out_ready;
  logic [MW-1:0] local_in_data;
  logic local_in_valid, local_in_ready;
  logic local_has_message_flying, local_has_odd_clusters;
  logic hub_has_message_flying, hub_has_odd_clusters;
  logic [1:0] tx_state_dbg;
`ifdef LEAF_HUB_ENDPOINT_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  leaf_hub_endpoint dut (
    .clk(clk), .reset(reset),
    .hub_in_data(hub_in_data), .hub_in_valid(hub_in_valid), .hub_in_ready(hub_in_ready),
    .hub_out_data(hub_out_data), .hub_out_valid(hub_out_valid), .hub_out_ready(hub_out_ready),
    .local_out_data(local_out_data), .local_out_valid(local_out_valid),
    .local_out_ready(local_out_ready),
    .local_in_data(local_in_data), .local_in_valid(local_in_valid),
    .local_in_ready(local_in_ready),
    .local_has_message_flying(local_has_message_flying),
    .local_has_odd_clusters(local_has_odd_clusters),
    .hub_has_message_flying(hub_has_message_flying),
    .hub_has_odd_clusters(hub_has_odd_clusters),
    .tx_state_dbg(tx_state_dbg)
`ifdef LEAF_HUB_ENDPOINT_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic hiv; logic [15:0] hid; logic lor; logic liv; logic [7:0] lid;
    logic hor; logic lhm; logic odd;
    logic e_lov; logic [7:0] e_lod; logic e_hir; logic e_hov; logic [15:0] e_hod;
    logic e_lir; logic e_fly; logic e_odd;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic hiv, input logic [15:0] hid, input logic lor,
                     input logic liv, input logic [7:0] lid, input logic hor,
                     input logic lhm, input logic odd,
                     input logic e_lov, input logic [7:0] e_lod, input logic e_hir,
                     input logic e_hov, input logic [15:0] e_hod, input logic e_lir,
                     input logic e_fly, input logic e_odd);
    vec_t v;
    v.hiv = hiv; v.hid = hid; v.lor = lor; v.liv = liv; v.lid = lid;
    v.hor = hor; v.lhm = lhm; v.odd = odd;
    v.e_lov = e_lov; v.e_lod = e_lod; v.e_hir = e_hir; v.e_hov = e_hov;
    v.e_hod = e_hod; v.e_lir = e_lir; v.e_fly = e_fly; v.e_odd = e_odd;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    hub_in_valid = 0; hub_in_data = '0; local_out_ready = 0;
    local_in_valid = 0; local_in_data = '0; hub_out_ready = 0;
    local_has_message_flying = 0; local_has_odd_clusters = 0;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic m_fly, m_odd;
  int m_drop;

  task automatic model_clear();
    rx_q.delete(); tx_q.delete(); m_fly = 0; m_odd = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic e_hir, e_lir, match, pop_rx, pop_tx;
    @(negedge clk);
    e_hir = !reset && (rx_q.size() < DEPTH || local_out_ready);
    e_lir = !reset && (tx_q.size() < 2);
    chk("m_local_out_valid", local_out_valid, rx_q.size() != 0);
    if (rx_q.size() != 0) chk("m_local_out_data", local_out_data, rx_q[0]);
    chk("m_hub_in_ready", hub_in_ready, e_hir);
    chk("m_local_in_ready", local_in_ready, e_lir);
    chk("m_hub_out_valid", hub_out_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("m_hub_out_data", hub_out_data, {MY_ID, tx_q[0]});
    chk("m_msg_flying", hub_has_message_flying, m_fly);
    chk("m_odd_clusters", hub_has_odd_clusters, m_odd);
`ifdef LEAF_HUB_ENDPOINT_DROP_COUNT_EN
    chk("m_drop_count", drop_count, m_drop);
`endif
    if (reset) begin
      model_clear();
    end else begin
      m_fly = local_has_message_flying || rx_q.size() != 0 || tx_q.size() != 0 || hub_in_valid;
      m_odd = local_has_odd_clusters;
      match = (hub_in_data[15:8] == MY_ID) || (hub_in_data[15:8] == 8'hFF);
      pop_rx = rx_q.size() != 0 && local_out_ready;
      pop_tx = tx_q.size() != 0 && hub_out_ready;
      if (pop_rx) void'(rx_q.pop_front());
      if (hub_in_valid && e_hir && match) rx_q.push_back(hub_in_data[7:0]);
      if (hub_in_valid && e_hir && !match && m_drop < 65535) m_drop++;
      if (pop_tx) void'(tx_q.pop_front());
      if (local_in_valid && e_lir) tx_q.push_back(local_in_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    drive_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // rx path: unicast, broadcast, drop, then fill to full
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 0,0);
    add(1,16'h015A,0, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 0,0);
    add(0,16'h0000,0, 0,8'h00,1,0,0,  1,8'h5A,1, 0,16'h0000,1, 1,0);
    add(1,16'hFF33,1, 0,8'h00,1,0,0,  1,8'h5A,1, 0,16'h0000,1, 1,0);
    add(1,16'h0244,1, 0,8'h00,1,0,0,  1,8'h33,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,1,  0,8'h00,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 0,1);
    add(1,16'h01A1,0, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 0,0);
    add(1,16'h01A2,0, 0,8'h00,1,0,0,  1,8'hA1,1, 0,16'h0000,1, 1,0);
    add(1,16'h01A3,0, 0,8'h00,1,0,0,  1,8'hA1,1, 0,16'h0000,1, 1,0);
    add(1,16'h01A4,0, 0,8'h00,1,0,0,  1,8'hA1,1, 0,16'h0000,1, 1,0);
    add(1,16'h01A5,0, 0,8'h00,1,0,0,  1,8'hA1,0, 0,16'h0000,1, 1,0);
    add(1,16'h01A5,1, 0,8'h00,1,0,0,  1,8'hA1,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,0, 0,8'h00,1,0,0,  1,8'hA2,0, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  1,8'hA2,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  1,8'hA3,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  1,8'hA4,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  1,8'hA5,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 0,0);
    // tx path with back-pressure from the hub
    add(0,16'h0000,1, 1,8'h11,0,0,0,  0,8'h00,1, 0,16'h0000,1, 0,0);
    add(0,16'h0000,1, 1,8'h22,0,0,0,  0,8'h00,1, 1,16'h0111,1, 0,0);
    add(0,16'h0000,1, 1,8'h33,0,0,0,  0,8'h00,1, 1,16'h0111,0, 1,0);
    add(0,16'h0000,1, 1,8'h33,1,0,0,  0,8'h00,1, 1,16'h0111,0, 1,0);
    add(0,16'h0000,1, 1,8'h33,0,0,0,  0,8'h00,1, 1,16'h0122,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 1,16'h0122,0, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 1,16'h0133,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 1,0);
    // one-cycle message_flying pulse with buffers empty
    add(0,16'h0000,1, 0,8'h00,1,1,0,  0,8'h00,1, 0,16'h0000,1, 0,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 1,0);
    add(0,16'h0000,1, 0,8'h00,1,0,0,  0,8'h00,1, 0,16'h0000,1, 0,0);

    foreach (vecs[i]) begin
      hub_in_valid = vecs[i].hiv; hub_in_data = vecs[i].hid;
      local_out_ready = vecs[i].lor; local_in_valid = vecs[i].liv;
      local_in_data = vecs[i].lid; hub_out_ready = vecs[i].hor;
      local_has_message_flying = vecs[i].lhm; local_has_odd_clusters = vecs[i].odd;
      @(negedge clk);
      chk($sformatf("v%0d_local_out_valid", i), local_out_valid, vecs[i].e_lov);
      if (vecs[i].e_lov) chk($sformatf("v%0d_local_out_data", i), local_out_data, vecs[i].e_lod);
      chk($sformatf("v%0d_hub_in_ready", i), hub_in_ready, vecs[i].e_hir);
      chk($sformatf("v%0d_hub_out_valid", i), hub_out_valid, vecs[i].e_hov);
      if (vecs[i].e_hov) chk($sformatf("v%0d_hub_out_data", i), hub_out_data, vecs[i].e_hod);
      chk($sformatf("v%0d_local_in_ready", i), local_in_ready, vecs[i].e_lir);
      chk($sformatf("v%0d_msg_flying", i), hub_has_message_flying, vecs[i].e_fly);
      chk($sformatf("v%0d_odd_clusters", i), hub_has_odd_clusters, vecs[i].e_odd);
`ifdef LEAF_HUB_ENDPOINT_DROP_COUNT_EN
      if (i == 5) chk("v5_drop_count", drop_count, 16'd1);
`endif
      @(posedge clk); #1;
    end

    // reset with RX holding 3 and TX full
    drive_idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      hub_in_valid = 1; hub_in_data = {8'h01, 8'(8'hC0 + k)};
      local_in_valid = 1; local_in_data = 8'(8'h40 + k);
      model_step();
    end
    drive_idle();
    model_step();
    reset = 1;
    model_step();
    reset = 0;
    repeat (2) model_step();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [7:0] h;
      case ($urandom_range(0, 3))
        0: h = MY_ID;
        1: h = 8'hFF;
        2: h = 8'h02;
        default: h = 8'($urandom_range(0, 255));
      endcase
      reset = ($urandom_range(0, 63) == 0);
      hub_in_valid = 1'($urandom_range(0, 1));
      hub_in_data = {h, 8'($urandom_range(0, 255))};
      local_out_ready = ($urandom_range(0, 3) != 0);
      local_in_valid = 1'($urandom_range(0, 1));
      local_in_data = 8'($urandom_range(0, 255));
      hub_out_ready = 1'($urandom_range(0, 1));
      local_has_message_flying = ($urandom_range(0, 7) == 0);
      local_has_odd_clusters = 1'($urandom_range(0, 1));
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
